// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 encodings of the supported access widths
//   - FSM state encoding (3 bits)
//   - is_misaligned(): alignment/legality rule shared by the FSM (on the
//     incoming request) and lsu_align (on the latched request)
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    // Unsupported encodings (011, 110, 111) are reported as misaligned so
    // they never touch memory.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic w_mis;
        case (funct3)
            F3_B, F3_BU: w_mis = 1'b0;
            F3_H, F3_HU: w_mis = addr_lo[0];
            F3_W:        w_mis = |addr_lo;
            default:     w_mis = 1'b1;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   i_funct3      access width / signedness
//   i_addr_lo     byte offset within the word
//   i_word        word read from memory (load source, or old word for RMW)
//   i_wdata       store data from the core (low byte/half used for sb/sh)
//   o_store_word  word to write back: i_wdata for sw, merged word for sb/sh
//   o_load_data   sign/zero-extended load result
//   o_misal       misaligned or unsupported access
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_data,
    output logic        o_misal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise an unassigned path infers a latch.
    always_comb begin
        w_byte       = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half       = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_load_data  = 32'h0;
        o_store_word = i_wdata;

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_data = i_word;
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = 32'h0;
        endcase

        // Store width comes from funct3[1:0]; sub-word stores keep the
        // untouched lanes of the old word.
        case (i_funct3[1:0])
            2'b00: begin
                o_store_word = i_word;
                o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            2'b01: begin
                o_store_word = i_word;
                o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: o_store_word = i_wdata;
        endcase

        o_misal = is_misaligned(i_funct3, i_addr_lo);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-wide DataMem.
// Accepts one byte-addressed request at a time, performs a read, a write or a
// read-modify-write on DataMem, and returns a one-cycle response.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we/req_funct3/req_addr/req_wdata   request fields
//   resp_valid/resp_rdata/resp_misal       one-cycle response
//   mem_read/mem_write/mem_addr/mem_wdata  DataMem word port controls
//   mem_rdata                   DataMem read data (combinational)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 6,
    parameter int ADDR_W = MEM_AW + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misal,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_data;

    logic [31:0]       w_store_word;
    logic [31:0]       w_load_data;
    logic              w_misal;

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr[1:0]),
        .i_word       (r_data),
        .i_wdata      (r_wdata),
        .o_store_word (w_store_word),
        .o_load_data  (w_load_data),
        .o_misal      (w_misal)
    );

    // Word address always comes from the latched request, so it is stable
    // for the whole busy window.
    assign mem_addr = r_addr[ADDR_W-1:2];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order. The request and
    // data registers are cleared on reset so no stale word can reach memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_data   <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && req_valid) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (r_state == RD || r_state == RMW_RD) begin
                r_data <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = 32'h0;
        resp_misal   = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = 32'h0;

        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // Alignment is judged on the incoming request so the
                    // error path skips memory entirely.
                    if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        w_next_state = RESP;
                    end else if (!req_we) begin
                        w_next_state = RD;
                    end else if (req_funct3[1:0] == F3_W[1:0]) begin
                        w_next_state = WR;
                    end else begin
                        w_next_state = RMW_RD;
                    end
                end
            end
            RD: begin
                mem_read     = 1'b1;
                w_next_state = RESP;
            end
            RMW_RD: begin
                mem_read     = 1'b1;
                w_next_state = WR;
            end
            WR: begin
                mem_write    = 1'b1;
                mem_wdata    = w_store_word;
                w_next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_misal = w_misal;
                if (!r_we && !w_misal) begin
                    resp_rdata = w_load_data;
                end
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule
